// File: rtl/apb4_master.sv
// APB4 master: bridges a valid/ready core request onto a single APB4 transfer.
// Latency: 3 cycles from an accepted bus_valid to the bus_ready pulse, plus 1 per PREADY=0 ACCESS cycle.
// Backpressure: the core holds bus_valid until bus_ready; the slave stalls the transfer with PREADY=0.
//
// Ports:
//   clk, rst_n                      - rising-edge clock, asynchronous active-low reset
//   bus_valid/addr/wdata/wstrb/write - core request (held until bus_ready)
//   bus_ready/rdata/err             - one-cycle completion pulse, read data and status (held)
//   PADDR/PWDATA/PSTRB/PWRITE/PSEL/PENABLE - APB4 master outputs
//   PRDATA/PREADY/PSLVERR           - APB4 slave responses
//
// Optional feature: define APB4_MASTER_TIMEOUT_EN to compile in an ACCESS-phase
// watchdog that aborts a transfer after TIMEOUT stalled cycles with bus_err=1.
module apb4_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic                  bus_write,
    output logic                  bus_ready,
    output logic [DATA_W-1:0]     bus_rdata,
    output logic                  bus_err,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    logic   w_start;
    logic   w_timeout;

    // bus_ready is high during the completion cycle; a still-high bus_valid
    // there belongs to the request just finished, so it must not be taken.
    assign w_start = (r_state == S_IDLE) && bus_valid && !bus_ready;

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Counts stalled ACCESS cycles; abort fires on the TIMEOUT-th one.
    assign w_timeout = (r_state == S_ACCESS) && !PREADY && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_start) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_ACCESS) && !PREADY) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SETUP;
                        PADDR   <= bus_addr;
                        PWDATA  <= bus_wdata;
                        PWRITE  <= bus_write;
                        // Reads never carry byte strobes on APB4.
                        PSTRB   <= bus_write ? bus_wstrb : '0;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    PENABLE <= 1'b1;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_state   <= S_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        bus_ready <= 1'b1;
                        bus_err   <= PSLVERR;
                        // Errored reads return zero rather than slave garbage.
                        if (!PWRITE) begin
                            bus_rdata <= PSLVERR ? '0 : PRDATA;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        bus_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        if (!PWRITE) begin
                            bus_rdata <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_master.sv
// Directed testbench for apb4_master.
// Stimulus and sampling happen 1 ns after each rising edge.
// The slave side is driven directly by the bench per scenario.
module tb_apb4_master;

    logic        clk;
    logic        rst_n;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_write;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb4_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_write (bus_write),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
        bus_valid = 1'b1;
        bus_write = wr;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_wstrb = strb;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_wstrb = 4'h0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        #12;
        chk("rst_psel",    PSEL,      1'b0);
        chk("rst_penable", PENABLE,   1'b0);
        chk("rst_ready",   bus_ready, 1'b0);
        chk("rst_err",     bus_err,   1'b0);
        chk("rst_rdata",   bus_rdata, 32'h0);
        chk("rst_paddr",   PADDR,     32'h0);

        // Write, zero wait states, request present as reset releases
        rst_n  = 1'b1;
        PREADY = 1'b1;
        req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        step();  // +1
        chk("w1_psel",    PSEL,    1'b1);
        chk("w1_penable", PENABLE, 1'b0);
        chk("w1_paddr",   PADDR,   32'h1000_0004);
        chk("w1_pwdata",  PWDATA,  32'hDEAD_BEEF);
        chk("w1_pstrb",   PSTRB,   4'hF);
        chk("w1_pwrite",  PWRITE,  1'b1);
        step();  // +2
        chk("w1_penable2", PENABLE, 1'b1);
        chk("w1_ready2",   bus_ready, 1'b0);
        step();  // +3
        chk("w1_ready3",   bus_ready, 1'b1);
        chk("w1_psel3",    PSEL,      1'b0);
        chk("w1_penable3", PENABLE,   1'b0);
        chk("w1_err",      bus_err,   1'b0);
        bus_valid = 1'b0;
        step();
        chk("w1_ready_drop", bus_ready, 1'b0);

        // Read with two stall cycles; bus_addr changes mid-ACCESS
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
        step();  // +1
        chk("r2_pstrb1",  PSTRB,  4'h0);
        chk("r2_pwrite",  PWRITE, 1'b0);
        step();  // +2
        chk("r2_penable", PENABLE, 1'b1);
        bus_addr = 32'h3000_0000;
        step();  // +3
        chk("r2_ready3",  bus_ready, 1'b0);
        chk("r2_paddr",   PADDR,     32'h2000_0000);
        chk("r2_pstrb3",  PSTRB,     4'h0);
        step();  // +4
        chk("r2_ready4",  bus_ready, 1'b0);
        chk("r2_penable4", PENABLE,  1'b1);
        PREADY = 1'b1;
        step();  // +5
        chk("r2_ready5",  bus_ready, 1'b1);
        chk("r2_rdata",   bus_rdata, 32'h1234_5678);
        chk("r2_err",     bus_err,   1'b0);
        bus_valid = 1'b0;
        PRDATA    = 32'h0;
        step();
        chk("r2_rdata_hold", bus_rdata, 32'h1234_5678);

        // Errored read, then a good write
        PSLVERR = 1'b1;
        PRDATA  = 32'hFFFF_FFFF;
        req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        step(); step(); step();
        chk("e3_ready", bus_ready, 1'b1);
        chk("e3_err",   bus_err,   1'b1);
        chk("e3_rdata", bus_rdata, 32'h0);
        bus_valid = 1'b0;
        PSLVERR   = 1'b0;
        step();
        req(1'b1, 32'h0000_0044, 32'h0000_0055, 4'h3);
        step(); step(); step();
        chk("e3w_ready", bus_ready, 1'b1);
        chk("e3w_err",   bus_err,   1'b0);
        chk("e3w_rdata", bus_rdata, 32'h0);
        bus_valid = 1'b0;
        step();

        // bus_valid held across completion: one idle cycle, then a new SETUP
        req(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF);
        step(); step(); step();
        chk("h4_ready", bus_ready, 1'b1);
        req(1'b0, 32'h0000_0200, 32'h1111_2222, 4'hF);
        PRDATA = 32'h0BAD_F00D;
        step();
        chk("h4_idle_psel",  PSEL,      1'b0);
        chk("h4_idle_ready", bus_ready, 1'b0);
        step();
        chk("h4_psel2",  PSEL,  1'b1);
        chk("h4_paddr2", PADDR, 32'h0000_0200);
        step(); step();
        chk("h4_ready2", bus_ready, 1'b1);
        chk("h4_rdata2", bus_rdata, 32'h0BAD_F00D);
        bus_valid = 1'b0;
        step();

        // Stalled read: watchdog abort or indefinite wait
        PREADY = 1'b0;
        req(1'b0, 32'h0000_0300, 32'h1111_2222, 4'hF);
        step();  // +1 SETUP
        step();  // +2 first ACCESS cycle
`ifdef APB4_MASTER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_wait_ready", bus_ready, 1'b0);
        end
        step();
        chk("t5_ready", bus_ready, 1'b1);
        chk("t5_err",   bus_err,   1'b1);
        chk("t5_psel",  PSEL,      1'b0);
        chk("t5_rdata", bus_rdata, 32'h0);
        bus_valid = 1'b0;
        step();
        // Re-enter ACCESS for the reset scenario
        req(1'b0, 32'h0000_0300, 32'h1111_2222, 4'hF);
        step(); step();
`else
        for (int i = 0; i < 100; i++) begin
            step();
        end
        chk("t5_psel",    PSEL,      1'b1);
        chk("t5_penable", PENABLE,   1'b1);
        chk("t5_ready",   bus_ready, 1'b0);
`endif

        // Reset asserted mid-ACCESS
        bus_valid = 1'b0;
        chk("r6_pre_penable", PENABLE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r6_psel",    PSEL,      1'b0);
        chk("r6_penable", PENABLE,   1'b0);
        chk("r6_paddr",   PADDR,     32'h0);
        chk("r6_pwdata",  PWDATA,    32'h0);
        chk("r6_pstrb",   PSTRB,     4'h0);
        chk("r6_pwrite",  PWRITE,    1'b0);
        chk("r6_rdata",   bus_rdata, 32'h0);
        chk("r6_err",     bus_err,   1'b0);
        PREADY = 1'b1;
        step();
        chk("r6_ready_a", bus_ready, 1'b0);
        step();
        chk("r6_ready_b", bus_ready, 1'b0);
        #2;
        rst_n = 1'b1;
        req(1'b1, 32'h0000_0500, 32'h0000_0077, 4'h1);
        step();
        chk("r6_new_paddr", PADDR, 32'h0000_0500);
        chk("r6_new_psel",  PSEL,  1'b1);
        step(); step();
        chk("r6_new_ready", bus_ready, 1'b1);
        chk("r6_new_err",   bus_err,   1'b0);
        bus_valid = 1'b0;
        step();
        chk("r6_final_ready", bus_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles allowed (1..255).
REQ-004 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port bus_valid  in  1  request from the core, held until bus_ready.
REQ-007 SHALL have port bus_addr  in  ADDR_W  request address.
REQ-008 SHALL have port bus_wdata  in  DATA_W  write data.
REQ-009 SHALL have port bus_wstrb  in  DATA_W/8  byte-lane write enables.
REQ-010 SHALL have port bus_write  in  1  direction: 1 = write, 0 = read.
REQ-011 SHALL have port bus_ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port bus_rdata  out  DATA_W  read data.
REQ-013 SHALL have port bus_err  out  1  error status of the completed transfer.
REQ-014 SHALL have ports PADDR (out, ADDR_W), PWDATA (out, DATA_W), PSTRB (out, DATA_W/8), PWRITE (out, 1), PSEL (out, 1), PENABLE (out, 1) carrying the APB4 master signals.
REQ-015 SHALL have ports PRDATA (in, DATA_W), PREADY (in, 1), PSLVERR (in, 1) carrying the APB4 slave responses.

Function
REQ-016 SHALL implement states IDLE, SETUP and ACCESS, with transitions as follows:
- IDLE -> SETUP on bus_valid=1 and bus_ready=0.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE on PREADY=1 or on timeout.
- Any other encoding -> IDLE.
REQ-017 SHALL, on the clock edge that leaves IDLE, register PADDR/PWDATA/PWRITE from the bus_* inputs; PSTRB = bus_wstrb for a write and all-zero for a read; PSEL=1, PENABLE=0.
REQ-018 SHALL hold PADDR, PWDATA, PSTRB and PWRITE stable from SETUP until completion, ignoring bus_* changes during that time.
REQ-019 SHALL drive PENABLE=1 in ACCESS only, with PSEL=1 throughout SETUP and ACCESS.
REQ-020 SHALL complete a transfer on the edge where PREADY=1 in ACCESS: PSEL=0 and PENABLE=0 after that edge, with bus_ready=1 for exactly the following cycle.
REQ-021 SHALL, at completion of a read, capture PRDATA into bus_rdata; a write SHALL leave bus_rdata unchanged.
REQ-022 SHALL, at completion, set bus_err = PSLVERR sampled together with PREADY; when bus_err=1, a read SHALL load bus_rdata with zero.
REQ-023 SHALL hold bus_rdata and bus_err until the next completion.
REQ-024 SHALL have a latency of 3 cycles from bus_valid sampled in IDLE to bus_ready=1 with zero wait states, plus 1 cycle per PREADY=0 cycle in ACCESS.
REQ-025 SHALL ignore bus_valid during the bus_ready cycle, so that a still-asserted bus_valid there is not re-accepted; a bus_valid still high on the next cycle SHALL start a new transfer.
REQ-026 SHALL ignore PREADY and PSLVERR outside ACCESS.

Reset
REQ-027 SHALL, on rst_n=0 and independent of clk, immediately force:
- state = IDLE
- PSEL = PENABLE = PWRITE = 0
- PADDR = PWDATA = PSTRB = 0
- bus_ready = bus_err = 0
- bus_rdata = 0
- timeout counter = 0
REQ-028 SHALL drop an in-flight transfer when reset is asserted mid-transfer, with no bus_ready pulse for it.
REQ-029 SHALL accept the first request on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile in the timeout watchdog only when the macro APB4_MASTER_TIMEOUT_EN is defined.
REQ-031 SHALL, with APB4_MASTER_TIMEOUT_EN defined, behave as follows:
- Count ACCESS cycles with PREADY=0.
- If the count reaches TIMEOUT, abort: PSEL=0, PENABLE=0, bus_ready pulse, bus_err=1, bus_rdata=0 for a read.
- Return to IDLE.
- Clear the counter on every entry to SETUP.
REQ-032 SHALL, without APB4_MASTER_TIMEOUT_EN, wait indefinitely in ACCESS, with no counter logic present and bus_err sourced only from PSLVERR.

Verification
REQ-033 SHALL pass: write addr 0x1000_0004, data 0xDEAD_BEEF, wstrb 0xF, PREADY=1 -> PSEL at cycle +1, PENABLE at +2, PSTRB=0xF, bus_ready at +3, bus_err=0.
REQ-034 SHALL pass: read addr 0x2000_0000 with PREADY low for 2 ACCESS cycles, PRDATA=0x1234_5678 -> bus_ready at +5, bus_rdata=0x1234_5678, PSTRB=0 throughout.
REQ-035 SHALL pass: read with PSLVERR=1, PREADY=1 -> bus_err=1, bus_rdata=0; a subsequent good write -> bus_err=0 and bus_rdata still 0.
REQ-036 SHALL pass, with APB4_MASTER_TIMEOUT_EN and TIMEOUT=4: PREADY held 0 -> abort after 4 ACCESS cycles, PSEL=0, bus_ready=1, bus_err=1; without the macro, still in ACCESS after 100 cycles.
REQ-037 SHALL pass: bus_valid held high across completion -> one idle cycle, then a second SETUP with the new bus_addr; bus_addr changed mid-ACCESS -> PADDR unchanged.
REQ-038 SHALL pass: rst_n pulsed low during ACCESS -> all outputs zero asynchronously, no bus_ready pulse, and a normal transfer completes after release.
